// File: rtl/simon_pkg.sv
// Shared types and helpers for the Simon Says button decoder.
package simon_pkg;

   localparam int unsigned NUM_BTN = 4;
   localparam int unsigned COLOR_W = 2;

   typedef logic [COLOR_W-1:0] color_t;

   localparam color_t COLOR_GREEN  = 2'd0;
   localparam color_t COLOR_RED    = 2'd1;
   localparam color_t COLOR_BLUE   = 2'd2;
   localparam color_t COLOR_YELLOW = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE         = 2'd0,
      ST_WAIT_PRESS   = 2'd1,
      ST_EVAL         = 2'd2,
      ST_WAIT_RELEASE = 2'd3
   } btn_dec_state_t;

   // One-hot button vector to colour code; anything else maps to 00.
   function automatic color_t btn_encode(input logic [NUM_BTN-1:0] v);
      case (v)
         4'b0001: return COLOR_GREEN;
         4'b0010: return COLOR_RED;
         4'b0100: return COLOR_BLUE;
         4'b1000: return COLOR_YELLOW;
         default: return COLOR_GREEN;
      endcase
   endfunction

   // A press is legal only when exactly one button is down.
   function automatic logic btn_legal(input logic [NUM_BTN-1:0] v);
      return $onehot(v);
   endfunction

endpackage

// File: rtl/btn_debounce.sv
// Single-bit 2-flop synchroniser followed by a stable-count debouncer.
module btn_debounce #(
   parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
   input  logic clk,
   input  logic rst,
   input  logic i_raw,
   output logic o_db
);

   localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             r_sync1;
   logic             r_sync2;
   logic             r_db;
   logic [CNT_W-1:0] r_cnt;

   // Synchronise, then flip the debounced value after a full stable run.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
         r_db    <= 1'b0;
         r_cnt   <= '0;
      end else begin
         r_sync1 <= i_raw;
         r_sync2 <= r_sync1;
         if (r_sync2 == r_db) begin
            r_cnt <= '0;
         end else if (r_cnt == CNT_LAST) begin
            r_db  <= r_sync2;
            r_cnt <= '0;
         end else begin
            r_cnt <= r_cnt + CNT_W'(1);
         end
      end
   end

   assign o_db = r_db;

endmodule

// File: rtl/simon_btn_decoder.sv
// Simon Says player-input decoder: debounces the four buttons, detects one
// clean press per arm, encodes it and checks it against the expected colour.
// Optional press timeout is built when SIMON_TIMEOUT_EN is defined.
module simon_btn_decoder
   import simon_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 500000,
   parameter int unsigned TIMEOUT_CYCLES  = 150000000
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [3:0]   btn,
   input  logic         arm,
   input  logic [1:0]   expected,
   output logic         ready,
   output logic         press_valid,
   output logic [1:0]   press_code,
   output logic         correct,
   output logic         wrong,
   output logic         timeout
);

   btn_dec_state_t r_state, w_next_state;
   logic [NUM_BTN-1:0] w_db;
   logic [NUM_BTN-1:0] r_press;
   color_t             r_expected;
   logic               r_pend, w_pend_nxt;
   logic               w_expire;
   logic               w_db_any;

   logic   r_ready, r_press_valid, r_correct, r_wrong, r_timeout;
   color_t r_press_code;
   logic   w_ready_nxt, w_press_valid_nxt, w_correct_nxt, w_wrong_nxt, w_timeout_nxt;
   color_t w_press_code_nxt;

   for (genvar g = 0; g < NUM_BTN; g++) begin : g_db
      btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
         .clk  (clk),
         .rst  (rst),
         .i_raw(btn[g]),
         .o_db (w_db[g])
      );
   end

   assign w_db_any = (w_db != '0);

`ifdef SIMON_TIMEOUT_EN
   localparam int unsigned TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

   logic [TO_W-1:0] r_to_cnt;

   // Cycles spent waiting for a press; restarted on entry and on re-arm.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_to_cnt <= '0;
      end else if ((r_state != ST_WAIT_PRESS) || arm) begin
         r_to_cnt <= '0;
      end else begin
         r_to_cnt <= r_to_cnt + TO_W'(1);
      end
   end

   // A press or a re-arm on the expiry cycle wins over the timeout.
   assign w_expire = (r_state == ST_WAIT_PRESS) && !w_db_any && !arm &&
                     (r_to_cnt == TO_LAST);
`else
   logic w_unused_to;
   assign w_unused_to = ^32'(TIMEOUT_CYCLES);
   assign w_expire    = 1'b0;
`endif

   // State register and remembered arm across a held-button release.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= ST_IDLE;
         r_pend  <= 1'b0;
      end else begin
         r_state <= w_next_state;
         r_pend  <= w_pend_nxt;
      end
   end

   // Next-state logic.
   always_comb begin
      w_next_state = r_state;
      w_pend_nxt   = r_pend;
      case (r_state)
         ST_IDLE: begin
            if (arm) begin
               if (w_db_any) begin
                  w_next_state = ST_WAIT_RELEASE;
                  w_pend_nxt   = 1'b1;
               end else begin
                  w_next_state = ST_WAIT_PRESS;
               end
            end
         end
         ST_WAIT_PRESS: begin
            if (w_db_any)      w_next_state = ST_EVAL;
            else if (w_expire) w_next_state = ST_IDLE;
         end
         ST_EVAL: w_next_state = ST_WAIT_RELEASE;
         ST_WAIT_RELEASE: begin
            if (!w_db_any) begin
               w_next_state = r_pend ? ST_WAIT_PRESS : ST_IDLE;
               w_pend_nxt   = 1'b0;
            end
         end
         default: w_next_state = ST_IDLE;
      endcase
   end

   // Next values of the registered outputs.
   always_comb begin
      w_ready_nxt       = (w_next_state == ST_WAIT_PRESS);
      w_press_valid_nxt = 1'b0;
      w_press_code_nxt  = r_press_code;
      w_correct_nxt     = 1'b0;
      w_wrong_nxt       = 1'b0;
      w_timeout_nxt     = 1'b0;
      if (r_state == ST_EVAL) begin
         w_press_valid_nxt = 1'b1;
         w_press_code_nxt  = btn_encode(r_press);
         w_correct_nxt     = btn_legal(r_press) && (btn_encode(r_press) == r_expected);
         w_wrong_nxt       = !w_correct_nxt;
      end else if (w_expire) begin
         w_timeout_nxt = 1'b1;
         w_wrong_nxt   = 1'b1;
      end
   end

   // Output registers plus latched expected code and captured press.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_ready       <= 1'b0;
         r_press_valid <= 1'b0;
         r_press_code  <= COLOR_GREEN;
         r_correct     <= 1'b0;
         r_wrong       <= 1'b0;
         r_timeout     <= 1'b0;
         r_expected    <= COLOR_GREEN;
         r_press       <= '0;
      end else begin
         r_ready       <= w_ready_nxt;
         r_press_valid <= w_press_valid_nxt;
         r_press_code  <= w_press_code_nxt;
         r_correct     <= w_correct_nxt;
         r_wrong       <= w_wrong_nxt;
         r_timeout     <= w_timeout_nxt;
         if (arm && ((r_state == ST_IDLE) || (r_state == ST_WAIT_PRESS) ||
                     ((r_state == ST_WAIT_RELEASE) && r_pend)))
            r_expected <= expected;
         if ((r_state == ST_WAIT_PRESS) && w_db_any)
            r_press <= w_db;
      end
   end

   assign ready       = r_ready;
   assign press_valid = r_press_valid;
   assign press_code  = r_press_code;
   assign correct     = r_correct;
   assign wrong       = r_wrong;
   assign timeout     = r_timeout;

endmodule

// File: tb/tb_simon_btn_decoder.sv
// Directed bench for simon_btn_decoder (DEBOUNCE_CYCLES=4, TIMEOUT_CYCLES=20).
// Timeout scenario adapts to SIMON_TIMEOUT_EN.
module tb_simon_btn_decoder;

   localparam int unsigned DEB = 4;
   localparam int unsigned TO  = 20;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [3:0] btn = 4'b0000;
   logic       arm = 1'b0;
   logic [1:0] expected = 2'd0;
   logic       ready, press_valid, correct, wrong, timeout;
   logic [1:0] press_code;

   int checks    = 0;
   int failures  = 0;
   int excl_viol = 0;

   simon_btn_decoder #(.DEBOUNCE_CYCLES(DEB), .TIMEOUT_CYCLES(TO)) dut (
      .clk        (clk),
      .rst        (rst),
      .btn        (btn),
      .arm        (arm),
      .expected   (expected),
      .ready      (ready),
      .press_valid(press_valid),
      .press_code (press_code),
      .correct    (correct),
      .wrong      (wrong),
      .timeout    (timeout)
   );

   always #5 clk = ~clk;

   // Strobe exclusivity watcher.
   always @(negedge clk) begin
      if (rst && (((int'(correct) + int'(wrong) + int'(timeout)) > 1) ||
                  (press_valid && timeout)))
         excl_viol++;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_arm(input logic [1:0] e);
      arm = 1'b1;
      expected = e;
      tick();
      arm = 1'b0;
   endtask

   task automatic release_wait();
      btn = 4'b0000;
      repeat (8) tick();
   endtask

   task automatic test_reset();
      rst = 1'b0;
      repeat (3) tick();
      checks++;
      if ({ready, press_valid, press_code, correct, wrong, timeout} !== 7'b0) begin
         failures++;
         $display("FAIL reset_outputs: got %b expected %b",
                  {ready, press_valid, press_code, correct, wrong, timeout}, 7'b0);
      end
      rst = 1'b1;
      repeat (5) tick();
      checks++;
      if (ready !== 1'b0) begin
         failures++;
         $display("FAIL reset_idle_ready: got %b expected 0", ready);
      end
   endtask

   task automatic test_correct_press();
      int n_pv = 0;
      int pv_tick = -1;
      do_arm(2'd2);
      checks++;
      if (ready !== 1'b1) begin
         failures++;
         $display("FAIL corr_ready_arm: got %b expected 1", ready);
      end
      btn = 4'b0100;
      for (int i = 1; i <= 10; i++) begin
         tick();
         if (press_valid) begin
            n_pv++;
            if (pv_tick < 0) pv_tick = i;
         end
         if (i == 7) begin
            checks++;
            if (ready !== 1'b0) begin
               failures++;
               $display("FAIL corr_ready_drop: got %b expected 0", ready);
            end
         end
         if (i == 8) begin
            checks++;
            if ({press_valid, press_code, correct, wrong} !== 5'b1_10_10) begin
               failures++;
               $display("FAIL corr_strobe: got %b expected %b",
                        {press_valid, press_code, correct, wrong}, 5'b1_10_10);
            end
         end
      end
      checks++;
      if (pv_tick !== 8) begin
         failures++;
         $display("FAIL corr_latency: got tick %0d expected tick 8", pv_tick);
      end
      repeat (5) begin
         tick();
         if (press_valid) n_pv++;
      end
      btn = 4'b0000;
      repeat (20) begin
         tick();
         if (press_valid) n_pv++;
      end
      checks++;
      if ({n_pv, press_code} !== {32'd1, 2'd2}) begin
         failures++;
         $display("FAIL corr_single_hold: got count %0d code %0d expected count 1 code 2",
                  n_pv, press_code);
      end
   endtask

   task automatic test_reset_mid_eval();
      int n_pv = 0;
      int n_rdy = 0;
      do_arm(2'd2);
      btn = 4'b0100;
      repeat (7) tick();
      rst = 1'b0;
      #1;
      checks++;
      if ({ready, press_valid, press_code, correct, wrong, timeout} !== 7'b0) begin
         failures++;
         $display("FAIL rst_mid_eval: got %b expected %b",
                  {ready, press_valid, press_code, correct, wrong, timeout}, 7'b0);
      end
      repeat (2) tick();
      rst = 1'b1;
      repeat (15) begin
         tick();
         if (press_valid) n_pv++;
         if (ready) n_rdy++;
      end
      checks++;
      if ({n_pv, n_rdy} !== 64'd0) begin
         failures++;
         $display("FAIL rst_no_strobe: got pv %0d ready %0d expected 0 0", n_pv, n_rdy);
      end
      release_wait();
   endtask

   task automatic test_bounce();
      int n_pv = 0;
      int pv_tick = -1;
      expected = 2'd2;
      for (int i = 0; i < 30; i++) begin
         btn = (i >= 12 || ((i / 2) % 2) == 0) ? 4'b0100 : 4'b0000;
         arm = (i == 6);
         tick();
         arm = 1'b0;
         if (i == 7) begin
            checks++;
            if (ready !== 1'b1) begin
               failures++;
               $display("FAIL bounce_ready: got %b expected 1", ready);
            end
         end
         if (press_valid) begin
            n_pv++;
            if (pv_tick < 0) pv_tick = i;
            checks++;
            if ({press_code, correct, wrong} !== 4'b10_10) begin
               failures++;
               $display("FAIL bounce_code: got %b expected %b",
                        {press_code, correct, wrong}, 4'b10_10);
            end
         end
      end
      checks++;
      if ({n_pv, pv_tick} !== {32'd1, 32'd19}) begin
         failures++;
         $display("FAIL bounce_count: got count %0d at %0d expected count 1 at 19", n_pv, pv_tick);
      end
      release_wait();
   endtask

   task automatic test_wrong_press();
      int n_pv = 0;
      do_arm(2'd1);
      btn = 4'b1000;
      for (int i = 1; i <= 10; i++) begin
         tick();
         if (press_valid) n_pv++;
         if (i == 8) begin
            checks++;
            if ({press_valid, press_code, correct, wrong} !== 5'b1_11_01) begin
               failures++;
               $display("FAIL wrong_code: got %b expected %b",
                        {press_valid, press_code, correct, wrong}, 5'b1_11_01);
            end
         end
      end
      release_wait();
      do_arm(2'd0);
      btn = 4'b0011;
      for (int i = 1; i <= 10; i++) begin
         tick();
         if (press_valid) n_pv++;
         if (i == 8) begin
            checks++;
            if ({press_valid, press_code, correct, wrong} !== 5'b1_00_01) begin
               failures++;
               $display("FAIL illegal_code: got %b expected %b",
                        {press_valid, press_code, correct, wrong}, 5'b1_00_01);
            end
         end
      end
      checks++;
      if (n_pv !== 2) begin
         failures++;
         $display("FAIL wrong_count: got %0d expected 2", n_pv);
      end
      release_wait();
   endtask

   task automatic test_held_at_arm();
      int n_pv = 0;
      btn = 4'b0001;
      repeat (8) tick();
      do_arm(2'd0);
      repeat (10) begin
         tick();
         if (press_valid) n_pv++;
      end
      checks++;
      if ({n_pv, ready} !== {32'd0, 1'b0}) begin
         failures++;
         $display("FAIL held_no_strobe: got pv %0d ready %b expected 0 0", n_pv, ready);
      end
      btn = 4'b0000;
      for (int i = 1; i <= 8; i++) begin
         tick();
         if (i == 6 || i == 7) begin
            checks++;
            if (ready !== (i == 7)) begin
               failures++;
               $display("FAIL held_ready_t%0d: got %b expected %b", i, ready, (i == 7));
            end
         end
      end
      btn = 4'b0001;
      for (int i = 1; i <= 10; i++) begin
         tick();
         if (press_valid) n_pv++;
         if (i == 8) begin
            checks++;
            if ({press_valid, press_code, correct, wrong} !== 5'b1_00_10) begin
               failures++;
               $display("FAIL held_then_press: got %b expected %b",
                        {press_valid, press_code, correct, wrong}, 5'b1_00_10);
            end
         end
      end
      checks++;
      if (n_pv !== 1) begin
         failures++;
         $display("FAIL held_count: got %0d expected 1", n_pv);
      end
      release_wait();
   endtask

   task automatic test_rearm();
      do_arm(2'd0);
      repeat (5) tick();
      do_arm(2'd3);
      btn = 4'b1000;
      for (int i = 1; i <= 10; i++) begin
         tick();
         if (i == 8) begin
            checks++;
            if ({press_valid, press_code, correct, wrong} !== 5'b1_11_10) begin
               failures++;
               $display("FAIL rearm_relatch: got %b expected %b",
                        {press_valid, press_code, correct, wrong}, 5'b1_11_10);
            end
         end
      end
      release_wait();
   endtask

   task automatic test_timeout();
      int n_pv = 0;
      int n_to = 0;
      int n_wr = 0;
      int to_tick = -1;
      do_arm(2'd1);
`ifdef SIMON_TIMEOUT_EN
      for (int i = 1; i <= 25; i++) begin
         tick();
         if (press_valid) n_pv++;
         if (timeout) begin
            n_to++;
            if (to_tick < 0) to_tick = i;
         end
         if (i == 19) begin
            checks++;
            if (ready !== 1'b1) begin
               failures++;
               $display("FAIL to_ready_before: got %b expected 1", ready);
            end
         end
         if (i == 20) begin
            checks++;
            if ({timeout, wrong, correct, press_valid, ready} !== 5'b11000) begin
               failures++;
               $display("FAIL to_strobe: got %b expected %b",
                        {timeout, wrong, correct, press_valid, ready}, 5'b11000);
            end
         end
      end
      checks++;
      if ({n_to, to_tick, n_pv} !== {32'd1, 32'd20, 32'd0}) begin
         failures++;
         $display("FAIL to_count: got to %0d at %0d pv %0d expected 1 at 20 pv 0",
                  n_to, to_tick, n_pv);
      end
`else
      repeat (100) begin
         tick();
         if (press_valid) n_pv++;
         if (timeout) n_to++;
         if (wrong) n_wr++;
      end
      checks++;
      if ({n_pv, n_to, n_wr, ready} !== {32'd0, 32'd0, 32'd0, 1'b1}) begin
         failures++;
         $display("FAIL no_to_wait: got pv %0d to %0d wrong %0d ready %b expected 0 0 0 1",
                  n_pv, n_to, n_wr, ready);
      end
`endif
   endtask

   initial begin
      test_reset();
      test_correct_press();
      test_reset_mid_eval();
      test_bounce();
      test_wrong_press();
      test_held_at_arm();
      test_rearm();
      test_timeout();
      checks++;
      if (excl_viol !== 0) begin
         failures++;
         $display("FAIL strobe_exclusive: got %0d violations expected 0", excl_viol);
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
